// File: rtl/user_insn_sched.sv
// Custom-instruction scheduler for the superkdf9 user port: runs LED, interrupt and add
// ops locally and forwards the rest to external units, with a forced-completion timeout.
module user_insn_sched #(
    parameter int NUM_UNITS = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          user_valid,
    input  logic [10:0]                   user_opcode,
    input  logic [31:0]                   user_operand_0,
    input  logic [31:0]                   user_operand_1,
    output logic [31:0]                   user_result,
    output logic                          user_complete,
    output logic [NUM_UNITS-1:0]          unit_req,
    output logic [7:0]                    unit_subop,
    output logic [31:0]                   unit_op0,
    output logic [31:0]                   unit_op1,
    input  logic [NUM_UNITS-1:0]          unit_ack,
    input  logic [NUM_UNITS-1:0][31:0]    unit_result,
    input  logic [31:0]                   intr_src,
    output logic [31:0]                   interrupt_n,
    output logic [3:0]                    led,
    output logic                          err
);
    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [10:0] OP_ADD = 11'h000, OP_LED = 11'h001, OP_RDPEND = 11'h002,
                            OP_WRMASK = 11'h003, OP_ACK = 11'h00F;

    typedef enum logic [2:0] {S_IDLE, S_LOCAL, S_WAIT, S_DONE, S_GAP} state_t;
    typedef struct packed {
        logic [10:0] opcode;
        logic [31:0] op0;
        logic [31:0] op1;
    } insn_t;

    state_t                 state, state_nxt;
    insn_t                  insn;
    logic [CNT_W-1:0]       cnt;
    logic [2:0][31:0]       sync_pipe;
    logic [31:0]            pending, mask, rise, ack_clr;
    logic [2:0]             dec_k;
    logic                   dispatch, ack_hit, tmo;
    logic [31:0]            ack_res, local_res;
    logic                   local_err;

    assign dec_k    = user_opcode[10:8];
    assign dispatch = (dec_k != 3'd0) && (dec_k <= 3'(NUM_UNITS));
    assign ack_hit  = (state == S_WAIT) && |(unit_ack & unit_req);
    assign tmo      = (state == S_WAIT) && !ack_hit && (cnt == CNT_LAST);

    always_comb begin
        ack_res = '0;
        for (int i = 0; i < NUM_UNITS; i++)
            if (unit_req[i]) ack_res = unit_result[i];
    end

    always_comb begin
        local_res = 32'hDEAD_0000 | 32'(insn.opcode);
        local_err = 1'b0;
        unique case (insn.opcode)
            OP_ADD:    local_res = insn.op0 + insn.op1;
            OP_LED:    local_res = '0;
            OP_RDPEND: local_res = pending;
            OP_WRMASK: local_res = mask;
            OP_ACK:    local_res = pending & ~insn.op0;
            default:   local_err = 1'b1;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (user_valid) state_nxt = dispatch ? S_WAIT : S_LOCAL;
            S_LOCAL: state_nxt = S_DONE;
            S_WAIT:  if (ack_hit || tmo) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_GAP;
            S_GAP:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        user_complete = (state == S_DONE);
        interrupt_n   = ~(pending & mask);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            insn        <= '0;
            cnt         <= '0;
            user_result <= '0;
            unit_req    <= '0;
            unit_subop  <= '0;
            unit_op0    <= '0;
            unit_op1    <= '0;
            led         <= '0;
            mask        <= '0;
            err         <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: if (user_valid) begin
                    insn <= '{opcode: user_opcode, op0: user_operand_0, op1: user_operand_1};
                    cnt  <= '0;
                    if (dispatch) begin
                        unit_req   <= NUM_UNITS'(1) << (dec_k - 3'd1);
                        unit_subop <= user_opcode[7:0];
                        unit_op0   <= user_operand_0;
                        unit_op1   <= user_operand_1;
                    end
                end
                S_LOCAL: begin
                    user_result <= local_res;
                    if (local_err)                 err  <= 1'b1;
                    if (insn.opcode == OP_LED)     led  <= insn.op0[3:0];
                    if (insn.opcode == OP_WRMASK)  mask <= insn.op0;
                end
                S_WAIT: begin
                    // An ack on the final count still wins over the timeout.
                    if (ack_hit) begin
                        unit_req    <= '0;
                        user_result <= ack_res;
                    end else if (tmo) begin
                        unit_req    <= '0;
                        user_result <= 32'hFFFF_FFFF;
                        err         <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Interrupt sources: 2-flop synchronizer plus one stage of history for edge detect.
    assign rise    = sync_pipe[1] & ~sync_pipe[2];
    assign ack_clr = (state == S_LOCAL && insn.opcode == OP_ACK) ? insn.op0 : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_pipe <= '0;
            pending   <= '0;
        end else begin
            sync_pipe <= {sync_pipe[1:0], intr_src};
            pending   <= (pending & ~ack_clr) | rise;
        end
    end
endmodule

// File: tb/tb_user_insn_sched.sv
// Directed bench for user_insn_sched: local ops, unit dispatch/ack/timeout, interrupts, reset.
module tb_user_insn_sched;
    localparam int NU  = 4;
    localparam int TMO = 255;

    logic                clk = 1'b0;
    logic                rst;
    logic                user_valid;
    logic [10:0]         user_opcode;
    logic [31:0]         user_operand_0, user_operand_1;
    logic [31:0]         user_result;
    logic                user_complete;
    logic [NU-1:0]       unit_req;
    logic [7:0]          unit_subop;
    logic [31:0]         unit_op0, unit_op1;
    logic [NU-1:0]       unit_ack;
    logic [NU-1:0][31:0] unit_result;
    logic [31:0]         intr_src;
    logic [31:0]         interrupt_n;
    logic [3:0]          led;
    logic                err;

    int n_vec = 0;
    int n_bad = 0;
    int cpl_cnt = 0;
    int req_hi_cnt = 0;

    user_insn_sched #(.NUM_UNITS(NU), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .user_valid(user_valid), .user_opcode(user_opcode),
        .user_operand_0(user_operand_0), .user_operand_1(user_operand_1),
        .user_result(user_result), .user_complete(user_complete), .unit_req(unit_req),
        .unit_subop(unit_subop), .unit_op0(unit_op0), .unit_op1(unit_op1),
        .unit_ack(unit_ack), .unit_result(unit_result), .intr_src(intr_src),
        .interrupt_n(interrupt_n), .led(led), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (user_complete) cpl_cnt++;
        if (|unit_req)     req_hi_cnt++;
    end

    // Issue one instruction, hold valid until complete, then idle through GAP into IDLE.
    task automatic run(input logic [10:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat);
        user_opcode = op; user_operand_0 = a; user_operand_1 = b; user_valid = 1'b1;
        lat = 0;
        while (lat < 600) begin
            @(posedge clk); #1; lat++;
            if (user_complete) break;
        end
        if (!user_complete) lat = -1;
        res = user_result;
        user_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_reset();
        rst = 1'b1; user_valid = 1'b0; unit_ack = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        int c0;
        rst = 1'b1; user_valid = 1'b0; user_opcode = '0; user_operand_0 = '0;
        user_operand_1 = '0; unit_ack = '0; unit_result = '0; intr_src = '0;
        #12;
        n_vec++; if (interrupt_n !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL rst_intn: got %h exp ffffffff", interrupt_n); end
        n_vec++; if (led !== 4'h0) begin n_bad++; $display("FAIL rst_led: got %h exp 0", led); end
        n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b exp 0", err); end
        n_vec++; if (unit_req !== '0) begin n_bad++; $display("FAIL rst_req: got %b exp 0", unit_req); end
        n_vec++; if (user_complete !== 1'b0 || user_result !== 32'h0) begin n_bad++; $display("FAIL rst_cpl: got %b/%h exp 0/0", user_complete, user_result); end
        n_vec++; if (unit_subop !== 8'h0 || unit_op0 !== 32'h0 || unit_op1 !== 32'h0) begin n_bad++; $display("FAIL rst_unit_regs: got %h %h %h exp 0", unit_subop, unit_op0, unit_op1); end
        @(posedge clk); #1;
        rst = 1'b0;
        c0 = cpl_cnt;
        repeat (20) begin @(posedge clk); #1; end
        n_vec++; if (cpl_cnt - c0 !== 0) begin n_bad++; $display("FAIL rst_idle_cpl: got %0d exp 0", cpl_cnt - c0); end
    endtask

    task automatic test_add_gap();
        int pulses = 0, first = 0;
        logic [31:0] res = '0;
        user_opcode = 11'h000; user_operand_0 = 32'h7FFF_FFFF; user_operand_1 = 32'h0000_0003;
        user_valid = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (user_complete) begin
                pulses++;
                if (pulses == 1) begin first = c; res = user_result; end
            end
            // Valid stays up through the GAP cycle that follows the complete pulse.
            if (c == 3) user_valid = 1'b0;
        end
        n_vec++; if (first !== 2) begin n_bad++; $display("FAIL add_latency: got %0d exp 2", first); end
        n_vec++; if (res !== 32'h8000_0002) begin n_bad++; $display("FAIL add_result: got %h exp 80000002", res); end
        n_vec++; if (pulses !== 1) begin n_bad++; $display("FAIL add_single_cpl: got %0d exp 1", pulses); end
    endtask

    task automatic test_led();
        logic [31:0] res; int lat;
        run(11'h001, 32'h0000_00A5, 32'h0, res, lat);
        n_vec++; if (lat !== 2) begin n_bad++; $display("FAIL led_latency: got %0d exp 2", lat); end
        n_vec++; if (res !== 32'h0) begin n_bad++; $display("FAIL led_result: got %h exp 0", res); end
        n_vec++; if (led !== 4'h5) begin n_bad++; $display("FAIL led_value: got %h exp 5", led); end
    endtask

    task automatic test_unit_ack();
        int req_cyc = 0, done_c = 0;
        logic [31:0] res = '0;
        logic [NU-1:0] req_at_done = '1;
        user_opcode = 11'h1A2; user_operand_0 = 32'h1111_1111; user_operand_1 = 32'h2222_2222;
        user_valid = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            unit_ack = '0;
            if (user_complete) begin
                done_c = c; res = user_result; req_at_done = unit_req; user_valid = 1'b0;
                break;
            end
            if (unit_req == 4'b0001) req_cyc++;
            if (c == 1) begin
                n_vec++; if (unit_subop !== 8'hA2 || unit_op0 !== 32'h1111_1111 || unit_op1 !== 32'h2222_2222) begin
                    n_bad++; $display("FAIL unit_latch: got %h %h %h exp a2 11111111 22222222", unit_subop, unit_op0, unit_op1); end
            end
            if (c == 2) begin unit_ack = 4'b0010; unit_result[1] = 32'hDEAD_BEEF; end
            if (c == 5) begin unit_ack = 4'b0001; unit_result[0] = 32'h1234_5678; end
        end
        unit_ack = '0;
        repeat (2) begin @(posedge clk); #1; end
        n_vec++; if (req_cyc !== 5) begin n_bad++; $display("FAIL unit_req_cycles: got %0d exp 5", req_cyc); end
        n_vec++; if (done_c !== 6) begin n_bad++; $display("FAIL unit_cpl_cycle: got %0d exp 6", done_c); end
        n_vec++; if (res !== 32'h1234_5678) begin n_bad++; $display("FAIL unit_result: got %h exp 12345678", res); end
        n_vec++; if (req_at_done !== '0) begin n_bad++; $display("FAIL unit_req_drop: got %b exp 0", req_at_done); end
        n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL unit_err: got %b exp 0", err); end
    endtask

    task automatic test_ack_at_timeout();
        int done_c = 0;
        logic [31:0] res = '0;
        user_opcode = 11'h240; user_operand_0 = 32'h0; user_operand_1 = 32'h0; user_valid = 1'b1;
        for (int c = 1; c <= 300; c++) begin
            @(posedge clk); #1;
            unit_ack = '0;
            if (user_complete) begin done_c = c; res = user_result; user_valid = 1'b0; break; end
            if (c == TMO) begin unit_ack = 4'b0010; unit_result[1] = 32'hCAFE_F00D; end
        end
        unit_ack = '0;
        repeat (2) begin @(posedge clk); #1; end
        n_vec++; if (done_c !== TMO + 1) begin n_bad++; $display("FAIL edge_ack_cycle: got %0d exp %0d", done_c, TMO + 1); end
        n_vec++; if (res !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL edge_ack_result: got %h exp cafef00d", res); end
        n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL edge_ack_err: got %b exp 0", err); end
    endtask

    task automatic test_illegal();
        logic [31:0] res; int lat, r0;
        r0 = req_hi_cnt;
        run(11'h500, 32'h0, 32'h0, res, lat);
        n_vec++; if (res !== 32'hDEAD_0500) begin n_bad++; $display("FAIL illegal_unit_result: got %h exp dead0500", res); end
        n_vec++; if (lat !== 2) begin n_bad++; $display("FAIL illegal_unit_latency: got %0d exp 2", lat); end
        n_vec++; if (req_hi_cnt - r0 !== 0) begin n_bad++; $display("FAIL illegal_unit_req: got %0d req cycles exp 0", req_hi_cnt - r0); end
        n_vec++; if (err !== 1'b1) begin n_bad++; $display("FAIL illegal_unit_err: got %b exp 1", err); end
        run(11'h007, 32'h0, 32'h0, res, lat);
        n_vec++; if (res !== 32'hDEAD_0007) begin n_bad++; $display("FAIL illegal_local_result: got %h exp dead0007", res); end
    endtask

    task automatic test_timeout();
        int req_cyc = 0, done_c = 0;
        logic [31:0] res = '0;
        pulse_reset();
        n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL tmo_err_cleared: got %b exp 0", err); end
        user_opcode = 11'h300; user_operand_0 = 32'h0; user_operand_1 = 32'h0; user_valid = 1'b1;
        for (int c = 1; c <= 400; c++) begin
            @(posedge clk); #1;
            if (user_complete) begin done_c = c; res = user_result; user_valid = 1'b0; break; end
            if (unit_req == 4'b0100) req_cyc++;
        end
        user_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        n_vec++; if (req_cyc !== TMO) begin n_bad++; $display("FAIL tmo_req_cycles: got %0d exp %0d", req_cyc, TMO); end
        n_vec++; if (done_c !== TMO + 1) begin n_bad++; $display("FAIL tmo_cpl_cycle: got %0d exp %0d", done_c, TMO + 1); end
        n_vec++; if (res !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL tmo_result: got %h exp ffffffff", res); end
        n_vec++; if (err !== 1'b1) begin n_bad++; $display("FAIL tmo_err: got %b exp 1", err); end
    endtask

    task automatic test_interrupts();
        logic [31:0] res; int lat;
        run(11'h003, 32'h0000_0010, 32'h0, res, lat);
        n_vec++; if (res !== 32'h0) begin n_bad++; $display("FAIL wrmask_old: got %h exp 0", res); end
        intr_src = 32'h0000_0011;
        @(posedge clk); #1;
        intr_src = 32'h0;
        @(posedge clk); #1;
        n_vec++; if (interrupt_n !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL intr_early: got %h exp ffffffff", interrupt_n); end
        @(posedge clk); #1;
        n_vec++; if (interrupt_n !== 32'hFFFF_FFEF) begin n_bad++; $display("FAIL intr_latency: got %h exp ffffffef", interrupt_n); end
        run(11'h002, 32'h0, 32'h0, res, lat);
        n_vec++; if (res !== 32'h0000_0011) begin n_bad++; $display("FAIL rdpend: got %h exp 00000011", res); end
        run(11'h00F, 32'h0000_0010, 32'h0, res, lat);
        n_vec++; if (res !== 32'h0000_0001) begin n_bad++; $display("FAIL ack_result: got %h exp 00000001", res); end
        n_vec++; if (interrupt_n !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL ack_intn: got %h exp ffffffff", interrupt_n); end
    endtask

    task automatic test_set_clear_collision();
        logic [31:0] res; int lat;
        // Edge reaches the pending register on the same clock the ACK clear lands.
        intr_src = 32'h0000_0010;
        @(posedge clk); #1;
        intr_src = 32'h0;
        run(11'h00F, 32'h0000_0010, 32'h0, res, lat);
        n_vec++; if (interrupt_n !== 32'hFFFF_FFEF) begin n_bad++; $display("FAIL collide_intn: got %h exp ffffffef", interrupt_n); end
        run(11'h002, 32'h0, 32'h0, res, lat);
        n_vec++; if (res !== 32'h0000_0011) begin n_bad++; $display("FAIL collide_pending: got %h exp 00000011", res); end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] res; int lat, c0;
        user_opcode = 11'h100; user_operand_0 = 32'h5; user_operand_1 = 32'h6; user_valid = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        n_vec++; if (unit_req !== 4'b0001) begin n_bad++; $display("FAIL midrst_req_before: got %b exp 0001", unit_req); end
        #2 rst = 1'b1;
        #1;
        n_vec++; if (unit_req !== '0 || user_complete !== 1'b0) begin n_bad++; $display("FAIL midrst_async: got req %b cpl %b exp 0 0", unit_req, user_complete); end
        user_valid = 1'b0;
        c0 = cpl_cnt;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        n_vec++; if (cpl_cnt - c0 !== 0 || unit_req !== '0) begin n_bad++; $display("FAIL midrst_discard: got cpl %0d req %b exp 0 0", cpl_cnt - c0, unit_req); end
        run(11'h000, 32'h0000_0001, 32'h0000_0002, res, lat);
        n_vec++; if (res !== 32'h3 || lat !== 2) begin n_bad++; $display("FAIL midrst_add: got %h lat %0d exp 3 lat 2", res, lat); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add_gap();
        test_led();
        test_unit_ack();
        test_ack_at_timeout();
        test_illegal();
        test_timeout();
        test_interrupts();
        test_set_clear_collision();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
